mem_rmw_ctrl: RTL and testbench

Multi-cycle memory access sequencer between the CPU memory port and the word-organised data RAM. It accepts one load or store request at a time and performs byte/halfword lane extraction with sign/zero extension. Sub-word stores are done as an internal read-modify-write (read word, merge lane, write word), so the RAM only ever sees full-word accesses. It replaces the combinational store-merge/load-extract path with a handshaked, registered sequence.

---
 rtl/mem_rmw_ctrl_if.sv | 31 +++
 rtl/mem_rmw_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_rmw_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rmw_ctrl_if.sv
// CPU request port and word-RAM port of the load/store sequencer, bundled as one interface.
interface mem_rmw_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              iReq;
  logic              iWr;
  logic [2:0]        iType;
  logic [31:0]       iAddr;
  logic [31:0]       iData;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
  logic [31:0]       oData;
  logic              oMemR;
  logic              oMemW;
  logic [ADDR_W-1:0] oMemAddr;
  logic [31:0]       oMemData;
  logic [31:0]       iMemData;

  // Handshake: a request is taken on the rising edge where iReq=1 and oBusy=0; the
  // access ends with exactly one cycle of oDone (or oErr), and iReq while oBusy=1 is dropped.
  modport slave (
    input  iReq, iWr, iType, iAddr, iData, iMemData,
    output oBusy, oDone, oErr, oData, oMemR, oMemW, oMemAddr, oMemData
  );

  modport master (
    output iReq, iWr, iType, iAddr, iData, iMemData,
    input  oBusy, oDone, oErr, oData, oMemR, oMemW, oMemAddr, oMemData
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Load/store sequencer: lane extract/extend for loads, read-modify-write for sub-word
// stores, so the RAM only sees full-word accesses.
module mem_rmw_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_rmw_ctrl_if.slave        bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE, S_ERR} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       odata_q, odata_d;

  size_e       req_size;
  logic        req_sgn;
  logic        req_mis;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] extracted;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^bus.iAddr[31:ADDR_W+2];

  // Codes 101-111 fall through to word.
  always_comb begin
    req_size = SZ_W;
    req_sgn  = 1'b0;
    case (bus.iType)
      3'b001:  req_size = SZ_H;
      3'b010:  begin req_size = SZ_H; req_sgn = 1'b1; end
      3'b011:  req_size = SZ_B;
      3'b100:  begin req_size = SZ_B; req_sgn = 1'b1; end
      default: req_size = SZ_W;
    endcase
    req_mis = ((req_size == SZ_W) && (bus.iAddr[1:0] != 2'b00)) ||
              ((req_size == SZ_H) && bus.iAddr[0]);
  end

  always_comb begin
    rd_byte   = bus.iMemData[{lane_q, 3'b000} +: 8];
    rd_half   = lane_q[1] ? bus.iMemData[31:16] : bus.iMemData[15:0];
    extracted = bus.iMemData;
    merged    = bus.iMemData;
    case (size_q)
      SZ_B: begin
        extracted = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
        merged[{lane_q, 3'b000} +: 8] = word_q[7:0];
      end
      SZ_H: begin
        extracted = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        if (lane_q[1]) merged[31:16] = word_q[15:0];
        else           merged[15:0]  = word_q[15:0];
      end
      default: begin
        extracted = bus.iMemData;
        merged    = bus.iMemData;
      end
    endcase
  end

  // word_q carries the store data from accept until CAP replaces it with the merged word.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    word_d  = word_q;
    odata_d = odata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iReq) begin
          wr_d   = bus.iWr;
          size_d = req_size;
          sgn_d  = req_sgn;
          lane_d = bus.iAddr[1:0];
          addr_d = bus.iAddr[ADDR_W+1:2];
          word_d = bus.iData;
          if (req_mis)                             state_d = S_ERR;
          else if (bus.iWr && (req_size == SZ_W))  state_d = S_WR;
          else                                     state_d = S_RD;
        end
      end
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        if (wr_q) begin
          word_d  = merged;
          state_d = S_WR;
        end else begin
          odata_d = extracted;
          state_d = S_DONE;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_W;
      sgn_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      word_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      odata_q <= odata_d;
    end
  end

  assign bus.oBusy    = (state_q != S_IDLE);
  assign bus.oDone    = (state_q == S_DONE);
  assign bus.oErr     = (state_q == S_ERR);
  assign bus.oMemR    = (state_q == S_RD);
  assign bus.oMemW    = (state_q == S_WR);
  assign bus.oMemAddr = addr_q;
  assign bus.oMemData = word_q;
  assign bus.oData    = odata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: directed requests against a RAM model, a transaction-level
// reference model checked every cycle, and literal checks of known results.
module tb_mem_rmw_ctrl;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  mem_rmw_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  mem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] ram [DEPTH] = '{default: 32'h0};
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.oMemW) ram[bus.oMemAddr] <= bus.oMemData;
    if (bus.oMemR) rd_q <= ram[bus.oMemAddr];
  end
  assign bus.iMemData = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]       mdl_mem [DEPTH] = '{default: 32'h0};
  logic [31:0]       mdl_odata;
  logic              active;
  logic              m_err, m_load;
  logic [31:0]       m_data, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  int                m_lat, m_rd, m_wr;
  int                rd_seen, wr_seen;
  int                cyc = 0;
  int                acc_cyc = 0;
  int                acc_q[$];

  task automatic model_accept(input logic wr, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] data);
    int          sz, k;
    logic        sgn, mis;
    logic [31:0] w, v, mask;
    k   = int'(addr[1:0]);
    w   = mdl_mem[addr[ADDR_W+1:2]];
    sz  = (typ == 3'd1 || typ == 3'd2) ? 2 : (typ == 3'd3 || typ == 3'd4) ? 1 : 4;
    sgn = (typ == 3'd2 || typ == 3'd4);
    mis = (sz == 4 && k != 0) || (sz == 2 && (k % 2) == 1);
    v   = w >> (8 * k);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    mask    = (sz == 4) ? 32'hFFFF_FFFF : ((sz == 2 ? 32'hFFFF : 32'hFF) << (8 * k));
    m_err   = mis;
    m_load  = !wr;
    m_data  = v;
    m_addr  = addr[ADDR_W+1:2];
    m_wdata = (w & ~mask) | ((data << (8 * k)) & mask);
    m_rd    = (!mis && (!wr || sz != 4)) ? 1 : 0;
    m_wr    = (!mis && wr) ? 1 : 0;
    m_lat   = mis ? 1 : (!wr ? 3 : (sz == 4 ? 2 : 4));
  endtask

  // ---------------- compare process ----------------
  initial begin
    active    = 1'b0;
    mdl_odata = 32'h0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active    = 1'b0;
      mdl_odata = 32'h0;
    end else begin
      if (bus.oMemR || bus.oMemW) begin
        chk("rw_exclusive", 32'(bus.oMemR & bus.oMemW), 32'h0);
        chk("rw_expected", 32'(active), 32'h1);
        chk("mem_addr", 32'(bus.oMemAddr), 32'(m_addr));
        if (bus.oMemR) rd_seen++;
        if (bus.oMemW) begin
          wr_seen++;
          chk("mem_wdata", bus.oMemData, m_wdata);
        end
      end
      if (active) begin
        chk("busy_active", 32'(bus.oBusy), 32'h1);
        if (bus.oDone || bus.oErr) begin
          chk("latency", cyc - acc_cyc, m_lat);
          chk("err_flag", 32'(bus.oErr), 32'(m_err));
          chk("done_flag", 32'(bus.oDone), 32'(!m_err));
          chk("rd_count", rd_seen, m_rd);
          chk("wr_count", wr_seen, m_wr);
          if (m_load && !m_err) mdl_odata = m_data;
          chk("odata", bus.oData, mdl_odata);
          if (m_wr != 0) mdl_mem[m_addr] = m_wdata;
          active = 1'b0;
        end else if (cyc - acc_cyc >= m_lat) begin
          chk("done_missing", 32'(bus.oDone | bus.oErr), 32'h1);
          active = 1'b0;
        end
      end else begin
        chk("busy_idle", 32'(bus.oBusy), 32'h0);
        chk("done_idle", 32'(bus.oDone), 32'h0);
        chk("err_idle", 32'(bus.oErr), 32'h0);
        if (bus.iReq) begin
          model_accept(bus.iWr, bus.iType, bus.iAddr, bus.iData);
          active  = 1'b1;
          acc_cyc = cyc;
          rd_seen = 0;
          wr_seen = 0;
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.oBusy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (bus.oBusy) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic req(input logic wr, input logic [2:0] typ,
                     input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.iWr   = wr;
    bus.iType = typ;
    bus.iAddr = addr;
    bus.iData = data;
    bus.iReq  = 1'b1;
    @(posedge clk); #1;
    bus.iReq  = 1'b0;
    bus.iWr   = 1'($urandom_range(0, 1));
    bus.iType = 3'($urandom_range(0, 7));
    bus.iAddr = $urandom;
    bus.iData = $urandom;
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.oBusy), 32'h0);
    chk({tag, "_done"},  32'(bus.oDone), 32'h0);
    chk({tag, "_err"},   32'(bus.oErr), 32'h0);
    chk({tag, "_memr"},  32'(bus.oMemR), 32'h0);
    chk({tag, "_memw"},  32'(bus.oMemW), 32'h0);
    chk({tag, "_odata"}, bus.oData, 32'h0);
    chk({tag, "_maddr"}, 32'(bus.oMemAddr), 32'h0);
    chk({tag, "_mdata"}, bus.oMemData, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst       = 1'b1;
    bus.iReq  = 1'b0;
    bus.iWr   = 1'b0;
    bus.iType = 3'b000;
    bus.iAddr = 32'h0;
    bus.iData = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // word store then word load
    req(1'b1, 3'b000, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_w4_word", ram[4], 32'hDEAD_BEEF);
    req(1'b0, 3'b000, 32'h0000_0010, 32'h0);
    chk("load_word", bus.oData, 32'hDEAD_BEEF);

    // sub-word read-modify-write
    req(1'b1, 3'b000, 32'h0000_0010, 32'h1122_3344);
    req(1'b1, 3'b011, 32'h0000_0012, 32'h1234_56AB);
    chk("ram_w4_byte", ram[4], 32'h11AB_3344);
    req(1'b1, 3'b001, 32'h0000_0010, 32'h9876_CAFE);
    chk("ram_w4_half", ram[4], 32'h11AB_CAFE);
    chk("store_keeps_odata", bus.oData, 32'hDEAD_BEEF);

    // extension
    req(1'b1, 3'b000, 32'h0000_0020, 32'h80F0_7F85);
    req(1'b0, 3'b100, 32'h0000_0020, 32'h0);
    chk("lb_0x20", bus.oData, 32'hFFFF_FF85);
    req(1'b0, 3'b011, 32'h0000_0020, 32'h0);
    chk("lbu_0x20", bus.oData, 32'h0000_0085);
    req(1'b0, 3'b100, 32'h0000_0021, 32'h0);
    chk("lb_0x21", bus.oData, 32'h0000_007F);
    req(1'b0, 3'b100, 32'h0000_0023, 32'h0);
    chk("lb_0x23", bus.oData, 32'hFFFF_FF80);
    req(1'b0, 3'b010, 32'h0000_0022, 32'h0);
    chk("lh_0x22", bus.oData, 32'hFFFF_80F0);
    req(1'b0, 3'b001, 32'h0000_0022, 32'h0);
    chk("lhu_0x22", bus.oData, 32'h0000_80F0);
    req(1'b0, 3'b111, 32'h0000_0020, 32'h0);
    chk("lw_type7", bus.oData, 32'h80F0_7F85);

    // misalignment
    req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    chk("mis_load_keeps_odata", bus.oData, 32'h80F0_7F85);
    req(1'b1, 3'b001, 32'h0000_0011, 32'hFFFF_FFFF);
    chk("mis_store_ram", ram[4], 32'h11AB_CAFE);

    // iReq held high across a sub-word store
    @(posedge clk); #1;
    acc_q.delete();
    bus.iWr   = 1'b1;
    bus.iType = 3'b011;
    bus.iAddr = 32'h0000_0020;
    bus.iData = 32'h0000_005A;
    bus.iReq  = 1'b1;
    n = 0;
    while (acc_q.size() < 2 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    bus.iReq = 1'b0;
    chk("held_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("held_gap", acc_q[1] - acc_q[0], 5);
    wait_idle();
    chk("ram_w8_held", ram[8], 32'h80F0_7F5A);

    // reset while in CAP of a sub-word store
    @(posedge clk); #1;
    bus.iWr   = 1'b1;
    bus.iType = 3'b011;
    bus.iAddr = 32'h0000_0013;
    bus.iData = 32'h0000_0000;
    bus.iReq  = 1'b1;
    @(posedge clk); #1;
    bus.iReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_cap");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_ram", ram[4], 32'h11AB_CAFE);

    // reset and request together
    @(posedge clk); #1;
    rst       = 1'b1;
    bus.iWr   = 1'b1;
    bus.iType = 3'b000;
    bus.iAddr = 32'h0000_0010;
    bus.iData = 32'h0000_0000;
    bus.iReq  = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    bus.iReq = 1'b0;
    @(negedge clk);
    chk("rst_req_busy", 32'(bus.oBusy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ram", ram[4], 32'h11AB_CAFE);

    // recovery after reset
    req(1'b0, 3'b001, 32'h0000_0012, 32'h0);
    chk("lhu_after_rst", bus.oData, 32'h0000_11AB);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
